// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle datapath and controller.
package mips_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUC_W   = 3;
   localparam int unsigned ALUOP_W  = 2;

   // Opcodes (instruction bits [31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   // R-type funct field (instruction bits [5:0])
   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

   // ALU operation codes consumed by the ALU
   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

   // Coarse ALU request from the FSM to the ALU decoder
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPEEX  = 4'd6,
      S_RTYPEWB  = 4'd7,
      S_BEQEX    = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JEX      = 4'd11
   } state_t;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse aluop plus the funct field to a 3-bit ALU code.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [FUNCT_W-1:0] funct,
   output logic [ALUC_W-1:0]  alucontrol
);

   // Decode; unknown funct and the unused aluop value fall back to add
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alucontrol = ALU_ADD;
               FUNCT_SUB: alucontrol = ALU_SUB;
               FUNCT_AND: alucontrol = ALU_AND;
               FUNCT_OR:  alucontrol = ALU_OR;
               FUNCT_SLT: alucontrol = ALU_SLT;
               default:   alucontrol = ALU_ADD;
            endcase
         end
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences instructions and drives datapath controls.
module mips_multicycle_controller
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               pcen,
   output logic               iord,
   output logic               memtoreg,
   output logic               regdst,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUC_W-1:0]  alucontrol
);

   state_t              state_q;
   state_t              state_d;
   logic [ALUOP_W-1:0]  aluop_c;
   logic                pcwrite_c;
   logic                branch_c;
   logic                mem_req_c;
   logic                memwrite_c;
   logic                irwrite_c;
   logic                regwrite_c;

   // State register; reset always returns to instruction fetch
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state and Moore output decode (memory strobes gated by mem_ready)
   always_comb begin
      state_d    = state_q;
      aluop_c    = ALUOP_ADD;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      mem_req_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            alusrcb   = 2'b01;
            if (mem_ready) begin
               irwrite_c = 1'b1;
               pcwrite_c = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            iord      = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg   = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_c  = 1'b1;
            iord       = 1'b1;
            memwrite_c = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop_c = ALUOP_FUNCT;
            state_d = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regwrite_c = 1'b1;
            regdst     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQEX: begin
            alusrca  = 1'b1;
            aluop_c  = ALUOP_SUB;
            branch_c = 1'b1;
            pcsrc    = 2'b01;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_JEX: begin
            pcsrc     = 2'b10;
            pcwrite_c = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural side-effect strobes are suppressed while reset is held
   assign mem_req  = mem_req_c  & ~reset;
   assign memwrite = memwrite_c & ~reset;
   assign irwrite  = irwrite_c  & ~reset;
   assign regwrite = regwrite_c & ~reset;
   assign pcen     = (pcwrite_c | (branch_c & zero)) & ~reset;

   alu_decoder u_alu_decoder (
      .aluop      (aluop_c),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule
